// File: rtl/pcpi_seq_mul.sv
`timescale 1ns/1ps
// pcpi_seq_mul -- sequential RV32M multiplier attached to a PicoRV32-style
// co-processor interface. Handles MUL, MULH, MULHSU and MULHU with a
// shift-and-add datapath that retires STEPS product bits per clock, giving
// a fixed latency of 64/STEPS RUN cycles plus one DONE cycle.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous, active-high reset
//   pcpi_valid  core presents an instruction
//   pcpi_insn   instruction word (decoded for the four multiply opcodes)
//   pcpi_rs1    operand A
//   pcpi_rs2    operand B
//   pcpi_wr     result is written to rd (one-cycle pulse with pcpi_ready)
//   pcpi_rd     result value, held until the next completion
//   pcpi_wait   instruction is claimed; core must stall
//   pcpi_ready  result valid, single cycle
module pcpi_seq_mul #(
  parameter int STEPS = 4  // legal: 1, 2, 4, 8, 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam logic [6:0] CYCLES = 7'(64 / STEPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;       // multiplicand, shifted left each step
  logic [63:0] b_q, b_d;       // multiplier, shifted right each step
  logic [63:0] acc_q, acc_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        hi_q, hi_d;     // 1: return acc[63:32], 0: acc[31:0]
  logic        done_q, done_d; // drives both pcpi_ready and pcpi_wr
  logic        ready_q;        // done_q delayed; blocks re-accepting the same insn
  logic [31:0] rd_q, rd_d;

  logic        match;
  logic        rs1_signed;
  logic        rs2_signed;
  logic [63:0] a_t, b_t, acc_t;

  // Only opcode, funct7 and funct3 take part in the decode.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // funct3[2]=0 selects MUL/MULH/MULHSU/MULHU; 1xx is DIV/REM and is not ours.
  assign match = (pcpi_insn[6:0] == 7'b0110011) &&
                 (pcpi_insn[31:25] == 7'b0000001) &&
                 !pcpi_insn[14];
  assign rs1_signed = (pcpi_insn[13:12] == 2'b01) || (pcpi_insn[13:12] == 2'b10);
  assign rs2_signed = (pcpi_insn[13:12] == 2'b01);

  assign pcpi_wait  = pcpi_valid & match & ~done_q;
  assign pcpi_ready = done_q;
  assign pcpi_wr    = done_q;
  assign pcpi_rd    = rd_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    rd_d    = rd_q;
    a_t     = a_q;
    b_t     = b_q;
    acc_t   = acc_q;

    unique case (state_q)
      IDLE: begin
        if (pcpi_valid && match && !ready_q) begin
          state_d = RUN;
          a_d     = rs1_signed ? {{32{pcpi_rs1[31]}}, pcpi_rs1} : {32'h0, pcpi_rs1};
          b_d     = rs2_signed ? {{32{pcpi_rs2[31]}}, pcpi_rs2} : {32'h0, pcpi_rs2};
          hi_d    = (pcpi_insn[13:12] != 2'b00);
          acc_d   = 64'h0;
          cnt_d   = CYCLES;
        end
      end

      RUN: begin
        if (!pcpi_valid) begin
          state_d = IDLE;
        end else begin
          // NOTE: blocking assignments are intentional inside this loop:
          // each step must see the previous step's partial sum and shifts.
          for (int i = 0; i < STEPS; i++) begin
            if (b_t[0]) acc_t = acc_t + a_t;
            a_t = {a_t[62:0], 1'b0};
            b_t = {1'b0, b_t[63:1]};
          end
          a_d   = a_t;
          b_d   = b_t;
          acc_d = acc_t;
          cnt_d = cnt_q - 7'd1;
          if (cnt_d == 7'd0) begin
            // Result is taken from the sum including this final step.
            state_d = DONE;
            done_d  = 1'b1;
            rd_d    = hi_q ? acc_t[63:32] : acc_t[31:0];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: all state, including the datapath registers, is reset so an
  // operation interrupted by reset leaves nothing behind to complete later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 64'h0;
      b_q     <= 64'h0;
      acc_q   <= 64'h0;
      cnt_q   <= 7'd0;
      hi_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      ready_q <= done_q;
      rd_q    <= rd_d;
    end
  end

endmodule
